// File: rtl/feeder_pkg.sv
// feeder_pkg: state encoding and sizing/skew helpers shared by the operand feeder.
package feeder_pkg;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARMED, S_FEED} state_t;

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Lane d is live on beat t when its skewed element index t-d lies in 0..n-1.
    function automatic logic skew_ok(input int t, input int d, input int n);
        return (t >= d) && (t - d < n);
    endfunction

endpackage

// File: rtl/feeder_operand_bank.sv
// feeder_operand_bank: N x N element store, linear-address write port and
// N parallel combinational (row, column) read ports.
module feeder_operand_bank
    import feeder_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8,
    localparam int AW = cnt_w(N * N),
    localparam int IW = cnt_w(N)
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [DW-1:0]        i_wdata,
    input  logic [N-1:0][IW-1:0] i_rd_row,
    input  logic [N-1:0][IW-1:0] i_rd_col,
    output logic [N-1:0][DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [N*N];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    for (genvar k = 0; k < N; k++) begin : g_rd
        assign o_rd_data[k] = r_mem[AW'(int'(i_rd_row[k]) * N + int'(i_rd_col[k]))];
    end

endmodule

// File: rtl/systolic_operand_feeder.sv
// systolic_operand_feeder: loads A then B word-serially and feeds them diagonally skewed
// onto the array edges. FEEDER_REUSE_B_EN keeps B across feeds so later loads carry A only.
module systolic_operand_feeder
    import feeder_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 8
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_enable,
    input  logic            i_ld_valid,
    input  logic [DW-1:0]   i_ld_data,
    output logic            o_ld_ready,
    input  logic            i_start,
    output logic [N*DW-1:0] o_a_out,
    output logic [N-1:0]    o_a_vld,
    output logic [N*DW-1:0] o_b_out,
    output logic [N-1:0]    o_b_vld,
    output logic            o_busy,
    output logic            o_done
);

    localparam int TW = cnt_w(2 * N - 1);
    localparam int LW = cnt_w(2 * N * N);
    localparam int AW = cnt_w(N * N);
    localparam int IW = cnt_w(N);
    localparam logic [LW-1:0] L_NN   = LW'(N * N);
    localparam logic [LW-1:0] L_FULL = LW'(2 * N * N - 1);
    localparam logic [TW-1:0] T_END  = TW'(2 * N - 1);

    state_t               r_state;
    logic [LW-1:0]        r_lcnt;
    logic [TW-1:0]        r_t;
    logic                 w_acc;
    logic                 w_last;
    logic                 w_end;
    logic [LW-1:0]        w_last_idx;
    logic [N-1:0]         w_v;
    logic [N-1:0][IW-1:0] w_lane;
    logic [N-1:0][IW-1:0] w_k;
    logic [N-1:0][DW-1:0] w_a_rd;
    logic [N-1:0][DW-1:0] w_b_rd;
    logic [N*DW-1:0]      w_a_beat;
    logic [N*DW-1:0]      w_b_beat;

    assign w_acc  = i_ld_valid && o_ld_ready;
    assign w_last = r_lcnt == w_last_idx;
    assign w_end  = r_t == T_END;

`ifdef FEEDER_REUSE_B_EN
    logic r_bheld;

    assign w_last_idx = r_bheld ? L_NN - LW'(1) : L_FULL;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_bheld <= 1'b0;
        else if (r_state == S_FEED && i_enable && w_end) r_bheld <= 1'b1;
    end
`else
    assign w_last_idx = L_FULL;
`endif

    feeder_operand_bank #(.N(N), .DW(DW)) u_bank_a (
        .i_clk     (i_clk),
        .i_we      (w_acc && r_lcnt < L_NN),
        .i_waddr   (AW'(r_lcnt)),
        .i_wdata   (i_ld_data),
        .i_rd_row  (w_lane),
        .i_rd_col  (w_k),
        .o_rd_data (w_a_rd)
    );

    feeder_operand_bank #(.N(N), .DW(DW)) u_bank_b (
        .i_clk     (i_clk),
        .i_we      (w_acc && r_lcnt >= L_NN),
        .i_waddr   (AW'(r_lcnt - L_NN)),
        .i_wdata   (i_ld_data),
        .i_rd_row  (w_k),
        .i_rd_col  (w_lane),
        .o_rd_data (w_b_rd)
    );

    // A row i and B column i share the same skew, so one validity/index per lane serves both.
    for (genvar i = 0; i < N; i++) begin : g_skew
        assign w_lane[i]             = IW'(i);
        assign w_v[i]                = skew_ok(int'(r_t), i, N);
        assign w_k[i]                = w_v[i] ? IW'(int'(r_t) - i) : '0;
        assign w_a_beat[i*DW +: DW]  = w_v[i] ? w_a_rd[i] : '0;
        assign w_b_beat[i*DW +: DW]  = w_v[i] ? w_b_rd[i] : '0;
    end

    // r_t names the beat latched at the next enabled edge; T_END means all beats are out.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_lcnt     <= '0;
            r_t        <= '0;
            o_a_out    <= '0;
            o_a_vld    <= '0;
            o_b_out    <= '0;
            o_b_vld    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_ld_ready <= 1'b1;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE, S_LOAD: if (w_acc) begin
                    r_lcnt     <= w_last ? '0 : r_lcnt + LW'(1);
                    r_state    <= w_last ? S_ARMED : S_LOAD;
                    o_ld_ready <= !w_last;
                end
                S_ARMED: if (i_start) begin
                    r_state <= S_FEED;
                    r_t     <= '0;
                end
                S_FEED: if (i_enable) begin
                    r_state    <= w_end ? S_IDLE : S_FEED;
                    r_t        <= w_end ? '0 : r_t + TW'(1);
                    o_a_out    <= w_end ? '0 : w_a_beat;
                    o_a_vld    <= w_end ? '0 : w_v;
                    o_b_out    <= w_end ? '0 : w_b_beat;
                    o_b_vld    <= w_end ? '0 : w_v;
                    o_busy     <= !w_end;
                    o_done     <= w_end;
                    o_ld_ready <= w_end;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
